azadi_prog_loader: RTL and testbench
====================================

Name: azadi_prog_loader

Overview:
UART boot-loader stage upstream of the SoC core. It captures a program image over the programming UART pin while the programming button is active and writes it word-by-word into instruction memory. It holds the core in reset during loading and releases it once the end-of-file word arrives. Its inputs are the raw prog pad, the rx pad and the logic-analyser clks_per_bit value.

Parameters:
ADDR_W, 10, instruction-memory word-address width
EOF_WORD, 32'h0000_0FFF, end-of-image marker word (never written to memory)

Ports:
clk_i  input  1  system clock (wb_clk_i domain)
rst_ni  input  1  synchronous active-low reset
prog_i  input  1  programming button, asynchronous pad level
clks_per_bit_i  input  16  UART bit period in clk_i cycles
uart_rx_i  input  1  UART 8N1 receive line, asynchronous, idles high
mem_gnt_i  input  1  memory accepts current write
core_rst_no  output  1  active-low reset to core; 0 while loading
mem_req_o  output  1  write request
mem_we_o  output  1  write enable (equals mem_req_o)
mem_addr_o  output  ADDR_W  word address
mem_wdata_o  output  32  write data
busy_o  output  1  loader in LOAD or DRAIN
done_o  output  1  sticky: image loaded
err_o  output  2  sticky: [0] framing error, [1] overrun/address overflow

Behaviour:
- Clock/reset: one clock, clk_i. rst_ni is synchronous and active-low. All state is cleared on the first edge with rst_ni=0, including mid-transfer.
- Reset values: core_rst_no=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, done_o=0, err_o=0.
- Input synchronisation: prog_i and uart_rx_i each pass through 2 flops. A prog rising edge is detected on the synced value.
- Top FSM states:
  - IDLE: core_rst_no=1. core_rst_no goes to 1 on the first edge after rst_ni is released.
  - LOAD: entered on a prog rising edge in IDLE, registered. On entry: core_rst_no=0, busy_o=1; clear done_o, err_o, byte counter and address.
  - DRAIN: entered when EOF_WORD completes in LOAD. Waits for any pending write to be granted, then goes to IDLE with done_o=1. core_rst_no=1 on the same edge.
  - A prog edge in LOAD or DRAIN is ignored.
- RX FSM (runs only in LOAD; the line is ignored otherwise):
  - Effective period P = max(clks_per_bit_i, 2), sampled at the start bit.
  - RX_IDLE: a synced low moves to START.
  - START: at count P>>1, if the line is still low go to DATA; otherwise treat as a glitch and return to RX_IDLE.
  - DATA: sample 8 bits, LSB first, every P cycles.
  - STOP: sample after P cycles. A stop bit of 1 delivers the byte. A stop bit of 0 sets err_o[0] and discards the byte; the byte counter is unchanged. Return to RX_IDLE.
- Word assembly: little-endian. Byte 0 goes to [7:0], byte 3 to [31:24]. A 2-bit counter wraps to 0 after the 4th byte.
- Completed word:
  - If it equals EOF_WORD: go to DRAIN and write nothing.
  - Otherwise: load mem_wdata_o, assert mem_req_o/mem_we_o on the next edge, and hold address and data stable until the cycle where mem_gnt_i=1. Drop req on the following edge and increment mem_addr_o.
- Overrun: if a word completes while a request is still pending, set err_o[1] and drop the new word. The pending write is unaffected.
- Address overflow: after writing address 2^ADDR_W-1, further non-EOF words are dropped and set err_o[1]. The address does not wrap.
- Latency: last stop-bit sample to mem_req_o is 1 cycle. With gnt tied high, the request is 1 cycle wide.

Test Plan:
- Reset with clks_per_bit_i=4 -> all outputs at reset values while rst_ni=0; core_rst_no=1 one edge after release; busy_o=0.
- Prog pulse, send bytes 78 56 34 12 FF 0F 00 00 (P=4), mem_gnt_i=1 -> exactly one write, addr 0, data 32'h12345678. Then done_o=1, core_rst_no=1, busy_o=0, err_o=0.
- Same image with mem_gnt_i delayed 5 cycles -> mem_req_o high for 6 cycles with addr/data stable; mem_addr_o=1 afterwards.
- Byte with stop bit 0, then 4 good bytes EF BE AD DE -> err_o[0]=1; write data 32'hDEADBEEF at addr 0.
- mem_gnt_i=0 while two words arrive -> err_o[1]=1. After gnt, only the first word is written and mem_addr_o=1.
- rst_ni=0 for one edge after 2 bytes of a word -> reset values. A new prog and 4 bytes yield a write at addr 0 with only the new bytes.

Source files
------------

// File: rtl/azadi_prog_loader.sv
// UART boot loader: while the prog button has started a load, receives 8N1 bytes,
// packs them little-endian into 32-bit words and writes them to instruction memory.
module azadi_prog_loader #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [31:0] EOF_WORD = 32'h0000_0FFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prog_i,
  input  logic [15:0]       clks_per_bit_i,
  input  logic              uart_rx_i,
  input  logic              mem_gnt_i,
  output logic              core_rst_no,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        err_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN} top_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_e;

  logic [1:0]        prog_sync_q, rx_sync_q;
  logic              prog_prev_q;
  top_e              state_q, state_d;
  rx_e               rx_q, rx_d;
  logic [15:0]       cnt_q, cnt_d, per_q, per_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [23:0]       word_q, word_d;
  logic              req_q, req_d, full_q, full_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              core_rst_q, core_rst_d, done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic              prog_rise, rx_bit, byte_ok;
  logic [31:0]       word_full;

  assign prog_rise = prog_sync_q[1] & ~prog_prev_q;
  assign rx_bit    = rx_sync_q[1];
  assign word_full = {shift_q, word_q};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prog_sync_q <= 2'b00;
      prog_prev_q <= 1'b0;
      rx_sync_q   <= 2'b11;
      state_q     <= S_IDLE;
      rx_q        <= RX_IDLE;
      cnt_q       <= '0;
      per_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      req_q       <= 1'b0;
      full_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      core_rst_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      prog_sync_q <= {prog_sync_q[0], prog_i};
      prog_prev_q <= prog_sync_q[1];
      rx_sync_q   <= {rx_sync_q[0], uart_rx_i};
      state_q     <= state_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      bcnt_q      <= bcnt_d;
      word_q      <= word_d;
      req_q       <= req_d;
      full_q      <= full_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      core_rst_q  <= core_rst_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rx_d       = rx_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    req_d      = req_q;
    full_d     = full_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    core_rst_d = core_rst_q;
    done_d     = done_q;
    err_d      = err_q;
    byte_ok    = 1'b0;

    // A granted write retires; the last address latches "full" instead of wrapping.
    if (req_q && mem_gnt_i) begin
      req_d = 1'b0;
      if (addr_q == '1) full_d = 1'b1;
      else              addr_d = addr_q + 1'b1;
    end

    case (state_q)
      S_LOAD: begin
        case (rx_q)
          RX_IDLE: if (!rx_bit) begin
            rx_d  = RX_START;
            cnt_d = 16'd1;
            per_d = (clks_per_bit_i < 16'd2) ? 16'd2 : clks_per_bit_i;
          end
          RX_START: begin
            if (cnt_q == (per_q >> 1)) begin
              cnt_d = 16'd1;
              bit_d = '0;
              rx_d  = rx_bit ? RX_IDLE : RX_DATA;
            end else cnt_d = cnt_q + 16'd1;
          end
          RX_DATA: begin
            if (cnt_q == per_q) begin
              cnt_d   = 16'd1;
              shift_d = {rx_bit, shift_q[7:1]};
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) rx_d = RX_STOP;
            end else cnt_d = cnt_q + 16'd1;
          end
          default: begin
            if (cnt_q == per_q) begin
              rx_d = RX_IDLE;
              if (rx_bit) byte_ok  = 1'b1;
              else        err_d[0] = 1'b1;
            end else cnt_d = cnt_q + 16'd1;
          end
        endcase

        if (byte_ok) begin
          bcnt_d = bcnt_q + 2'd1;
          case (bcnt_q)
            2'd0: word_d[7:0]   = shift_q;
            2'd1: word_d[15:8]  = shift_q;
            2'd2: word_d[23:16] = shift_q;
            default: begin
              if (word_full == EOF_WORD) state_d = S_DRAIN;
              else if (req_q || full_q)  err_d[1] = 1'b1;
              else begin
                req_d   = 1'b1;
                wdata_d = word_full;
              end
            end
          endcase
        end
      end
      S_DRAIN: begin
        rx_d = RX_IDLE;
        if (!req_q || mem_gnt_i) begin
          state_d    = S_IDLE;
          done_d     = 1'b1;
          core_rst_d = 1'b1;
        end
      end
      default: begin
        rx_d       = RX_IDLE;
        core_rst_d = 1'b1;
        if (prog_rise) begin
          state_d    = S_LOAD;
          core_rst_d = 1'b0;
          done_d     = 1'b0;
          err_d      = '0;
          bcnt_d     = '0;
          addr_d     = '0;
          full_d     = 1'b0;
        end
      end
    endcase
  end

  assign core_rst_no = core_rst_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = req_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_azadi_prog_loader.sv
// Bench for azadi_prog_loader: directed vector table, hand-written corner sequences,
// and randomized images checked against a word-list model.
module tb_azadi_prog_loader;
  localparam int AW = 3;
  localparam logic [31:0] EOFW = 32'h0000_0FFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni, prog_i, uart_rx_i;
  logic          mem_gnt_i = 1'b0;
  logic [15:0]   cpb_i;
  logic          core_rst_no, mem_req_o, mem_we_o, busy_o, done_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [1:0]    err_o;

  azadi_prog_loader #(.ADDR_W(AW), .EOF_WORD(EOFW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .prog_i(prog_i), .clks_per_bit_i(cpb_i),
    .uart_rx_i(uart_rx_i), .mem_gnt_i(mem_gnt_i), .core_rst_no(core_rst_no),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder: grants after gdly request cycles, logs accepted writes.
  int gdly = 0, reqcnt = 0, maxreq = 0, stab_err = 0;
  bit ghold = 1'b0;
  logic [31:0] wa_q[$], wd_q[$];
  logic [AW-1:0] pa;
  logic [31:0] pd;
  always @(negedge clk) begin
    if (mem_req_o !== 1'b1) begin
      reqcnt = 0;
      mem_gnt_i = 1'b0;
    end else begin
      reqcnt++;
      if (reqcnt > 1 && (mem_addr_o !== pa || mem_wdata_o !== pd)) stab_err++;
      pa = mem_addr_o;
      pd = mem_wdata_o;
      if (reqcnt > maxreq) maxreq = reqcnt;
      mem_gnt_i = !ghold && (reqcnt > gdly);
      if (mem_gnt_i) begin
        wa_q.push_back(32'(mem_addr_o));
        wd_q.push_back(mem_wdata_o);
      end
    end
  end

  int cpb = 4;

  task automatic clear_log();
    wa_q.delete(); wd_q.delete();
    maxreq = 0; stab_err = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok);
    int p;
    p = (cpb < 2) ? 2 : cpb;
    uart_rx_i = 1'b0; repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = b[i]; repeat (p) @(negedge clk);
    end
    uart_rx_i = ok; repeat (p) @(negedge clk);
    uart_rx_i = 1'b1; repeat (2 * p + 2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic pulse_prog();
    prog_i = 1'b1; repeat (3) @(negedge clk);
    prog_i = 1'b0; repeat (4) @(negedge clk);
  endtask

  task automatic start_load(input string nm);
    clear_log();
    pulse_prog();
    check({nm, ".busy_on"}, busy_o, 1);
    check({nm, ".core_held"}, core_rst_no, 0);
    check({nm, ".done_clr"}, done_o, 0);
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (busy_o && t < 20000) begin @(negedge clk); t++; end
    check({nm, ".finished_in_budget"}, (t < 20000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst_ni = 1'b0;
    repeat (n) @(negedge clk);
    check("rst.core_rst_no", core_rst_no, 0);
    check("rst.req_we", {mem_req_o, mem_we_o}, 0);
    check("rst.addr", mem_addr_o, 0);
    check("rst.wdata", mem_wdata_o, 0);
    check("rst.busy_done_err", {busy_o, done_o, err_o}, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    check("rst.core_release", core_rst_no, 1);
    check("rst.busy_after", busy_o, 0);
  endtask

  function automatic logic [31:0] nth(input int j, input bit is_data);
    if (is_data) return (j < wd_q.size()) ? wd_q[j] : 32'hxxxx_xxxx;
    return (j < wa_q.size()) ? wa_q[j] : 32'hxxxx_xxxx;
  endfunction

  typedef struct packed {
    logic [15:0] cpb;
    logic [7:0]  gdly;
    logic [7:0]  nb;
    logic [95:0] bytes;
    logic [11:0] bad;
    logic [31:0] d0;
    logic [1:0]  err;
    logic [7:0]  maxreq;
  } vec_t;
  vec_t vecs[3];

  initial begin
    logic [95:0] bb;
    rst_ni = 1'b0; prog_i = 1'b0; uart_rx_i = 1'b1; cpb_i = 16'd4;

    vecs[0] = '{cpb: 16'd4, gdly: 8'd0, nb: 8'd8, bytes: 96'h0000_0FFF_1234_5678,
                bad: 12'h000, d0: 32'h1234_5678, err: 2'b00, maxreq: 8'd1};
    vecs[1] = '{cpb: 16'd4, gdly: 8'd5, nb: 8'd8, bytes: 96'h0000_0FFF_1234_5678,
                bad: 12'h000, d0: 32'h1234_5678, err: 2'b00, maxreq: 8'd6};
    vecs[2] = '{cpb: 16'd4, gdly: 8'd0, nb: 8'd9, bytes: 96'h0000_0000_0FFF_DEAD_BEEF_00,
                bad: 12'h001, d0: 32'hDEAD_BEEF, err: 2'b01, maxreq: 8'd1};

    do_reset(2);

    for (int i = 0; i < 3; i++) begin
      cpb = int'(vecs[i].cpb); cpb_i = vecs[i].cpb; gdly = int'(vecs[i].gdly);
      bb = vecs[i].bytes;
      start_load($sformatf("v%0d", i));
      for (int k = 0; k < int'(vecs[i].nb); k++) send_byte(bb[8*k +: 8], !vecs[i].bad[k]);
      wait_idle($sformatf("v%0d", i));
      check($sformatf("v%0d.nwrites", i), wa_q.size(), 1);
      check($sformatf("v%0d.addr0", i), nth(0, 0), 0);
      check($sformatf("v%0d.data0", i), nth(0, 1), vecs[i].d0);
      check($sformatf("v%0d.req_width", i), maxreq, vecs[i].maxreq);
      check($sformatf("v%0d.stable", i), stab_err, 0);
      check($sformatf("v%0d.addr_after", i), mem_addr_o, 1);
      check($sformatf("v%0d.err", i), err_o, vecs[i].err);
      check($sformatf("v%0d.done_core_busy", i), {done_o, core_rst_no, busy_o}, 3'b110);
    end

    // Overrun: second word arrives while the first is still waiting for a grant.
    cpb = 3; cpb_i = 16'd3; gdly = 0; ghold = 1'b1;
    start_load("ovr");
    send_word(32'h4433_2211);
    send_word(32'h8877_6655);
    check("ovr.err", err_o, 2'b10);
    check("ovr.req_pending", mem_req_o, 1);
    check("ovr.we", mem_we_o, 1);
    check("ovr.data_held", mem_wdata_o, 32'h4433_2211);
    check("ovr.addr_held", mem_addr_o, 0);
    ghold = 1'b0;
    repeat (3) @(negedge clk);
    check("ovr.req_dropped", mem_req_o, 0);
    check("ovr.addr_inc", mem_addr_o, 1);
    send_word(EOFW);
    wait_idle("ovr");
    check("ovr.nwrites", wa_q.size(), 1);
    check("ovr.data0", nth(0, 1), 32'h4433_2211);
    check("ovr.err_final", err_o, 2'b10);
    check("ovr.done", done_o, 1);

    // Reset in the middle of a word, then a fresh image.
    cpb = 4; cpb_i = 16'd4;
    start_load("mid");
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    do_reset(1);
    check("mid.no_write", wa_q.size(), 0);
    start_load("mid2");
    send_word(32'h0403_0201);
    send_word(EOFW);
    wait_idle("mid2");
    check("mid2.nwrites", wa_q.size(), 1);
    check("mid2.addr0", nth(0, 0), 0);
    check("mid2.data0", nth(0, 1), 32'h0403_0201);

    // Random images: expected writes are simply the first 2^AW words, in order.
    for (int it = 0; it < 6; it++) begin
      int nw, nexp;
      bit anybad;
      logic [31:0] w;
      logic [31:0] exp_q[$];
      cpb = $urandom_range(0, 6); cpb_i = 16'(cpb);
      gdly = $urandom_range(0, 3);
      nw = $urandom_range(1, 10);
      anybad = 1'b0;
      exp_q.delete();
      start_load($sformatf("rnd%0d", it));
      for (int j = 0; j < nw; j++) begin
        w = $urandom;
        if (w == EOFW) w = w ^ 32'h1;
        exp_q.push_back(w);
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(0, 7) == 0) begin
            send_byte(8'($urandom), 1'b0);
            anybad = 1'b1;
          end
          send_byte(w[8*k +: 8], 1'b1);
        end
        if (j == 0) pulse_prog();
      end
      send_word(EOFW);
      wait_idle($sformatf("rnd%0d", it));
      nexp = (nw > (1 << AW)) ? (1 << AW) : nw;
      check($sformatf("rnd%0d.nwrites", it), wa_q.size(), nexp);
      for (int j = 0; j < nexp; j++) begin
        check($sformatf("rnd%0d.addr%0d", it, j), nth(j, 0), j);
        check($sformatf("rnd%0d.data%0d", it, j), nth(j, 1), exp_q[j]);
      end
      check($sformatf("rnd%0d.err", it), err_o, {nw > (1 << AW), anybad});
      check($sformatf("rnd%0d.addr_final", it), mem_addr_o,
            (nw >= (1 << AW)) ? (1 << AW) - 1 : nw);
      check($sformatf("rnd%0d.stable", it), stab_err, 0);
      check($sformatf("rnd%0d.done_core", it), {done_o, core_rst_no}, 2'b11);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
